logic_unit_pipe: RTL and testbench

- Parametrised, pipelined successor to the team's single-bit dataflow gate block.
- Applies one of eight bitwise logic functions to WIDTH-bit operands and returns the result with zero, all-ones and parity flags.
- Has a valid/ready handshake on both sides and an accumulate mode that replaces operand A with the previous result.
- Sits between a stimulus or register source and any consumer that needs back-pressure.

---
 rtl/logic_unit_pkg.sv | 31 +++
 rtl/logic_unit_core.sv | 46 ++++
 rtl/logic_unit_pipe.sv | 149 ++++++++++++++
 tb/tb_logic_unit_pipe.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// ---------------------------------------------------------------------------
// logic_unit_pkg
// Shared types for the pipelined logic unit.
//   op_e        : 3-bit function select (AND .. PASS B)
//   stage_pay_t : payload captured by the first pipeline stage. Operand
//                 fields are MAX_WIDTH wide so one struct serves every
//                 WIDTH; narrower instances zero-extend into it.
// ---------------------------------------------------------------------------
package logic_unit_pkg;

    localparam int MAX_WIDTH = 64;

    typedef enum logic [2:0] {
        OP_AND   = 3'd0,
        OP_OR    = 3'd1,
        OP_NAND  = 3'd2,
        OP_NOR   = 3'd3,
        OP_XOR   = 3'd4,
        OP_XNOR  = 3'd5,
        OP_NOTA  = 3'd6,
        OP_PASSB = 3'd7
    } op_e;

    typedef struct packed {
        logic [MAX_WIDTH-1:0] a;
        logic [MAX_WIDTH-1:0] b;
        op_e                  op;
        logic                 acc;
    } stage_pay_t;

endpackage

// File: rtl/logic_unit_core.sv
// ---------------------------------------------------------------------------
// logic_unit_core
// Purely combinational bitwise function unit with result flags.
// Ports:
//   op      in   function select
//   a_eff   in   effective operand A (accumulator or external a)
//   b       in   operand B
//   y       out  WIDTH-bit result
//   zero    out  y is all zeros
//   ones    out  y is all ones
//   parity  out  XOR-reduction of y
// ---------------------------------------------------------------------------
module logic_unit_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] a_eff,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             ones,
    output logic             parity
);

    always_comb begin
        y = '0;
        unique case (op)
            OP_AND:   y = a_eff & b;
            OP_OR:    y = a_eff | b;
            OP_NAND:  y = ~(a_eff & b);
            OP_NOR:   y = ~(a_eff | b);
            OP_XOR:   y = a_eff ^ b;
            OP_XNOR:  y = ~(a_eff ^ b);
            OP_NOTA:  y = ~a_eff;
            OP_PASSB: y = b;
            default:  y = '0;
        endcase
    end

    assign zero   = (y == '0);
    assign ones   = &y;
    assign parity = ^y;

endmodule

// File: rtl/logic_unit_pipe.sv
// ---------------------------------------------------------------------------
// logic_unit_pipe
// Two-stage valid/ready pipeline around logic_unit_core with an accumulator
// that can stand in for operand A.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake
//   a, b, op, acc       operands, function select, use-accumulator bit
//   acc_clr             load ACC_INIT into the accumulator
//   out_valid/out_ready output handshake
//   y                   result
//   out_zero/ones/parity flags, registered together with y
// ---------------------------------------------------------------------------
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             acc,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             out_zero,
    output logic             out_ones,
    output logic             out_parity
);

    stage_pay_t       s1_pay_d, s1_pay_q;
    logic             s1_valid_d, s1_valid_q;
    logic             out_valid_d, out_valid_q;
    logic [WIDTH-1:0] y_d, y_q;
    logic             zero_d, zero_q;
    logic             ones_d, ones_q;
    logic             parity_d, parity_q;
    logic [WIDTH-1:0] acc_d, acc_q;

    logic [WIDTH-1:0] a_eff;
    logic [WIDTH-1:0] core_y;
    logic             core_zero, core_ones, core_parity;
    logic             s2_adv, s1_xfer, in_accept;

    // in_ready depends only on pipeline state and out_ready, never on in_valid.
    assign s2_adv    = !out_valid_q || out_ready;
    assign s1_xfer   = s1_valid_q && s2_adv;
    assign in_ready  = !s1_valid_q || s2_adv;
    assign in_accept = in_valid && in_ready;

    // Accumulator is read as the beat leaves S1, so it already holds the
    // previous beat's result and back-to-back acc beats chain without a bubble.
    assign a_eff = s1_pay_q.acc ? acc_q : s1_pay_q.a[WIDTH-1:0];

    logic_unit_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op     (s1_pay_q.op),
        .a_eff  (a_eff),
        .b      (s1_pay_q.b[WIDTH-1:0]),
        .y      (core_y),
        .zero   (core_zero),
        .ones   (core_ones),
        .parity (core_parity)
    );

    // Upper payload bits are constant zero padding for narrow instances.
    if (WIDTH < MAX_WIDTH) begin : g_pad
        logic unused_pad;
        assign unused_pad = ^{s1_pay_q.a[MAX_WIDTH-1:WIDTH],
                              s1_pay_q.b[MAX_WIDTH-1:WIDTH]};
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_pay_d   = s1_pay_q;
        if (in_accept) begin
            s1_valid_d   = 1'b1;
            s1_pay_d.a   = MAX_WIDTH'(a);
            s1_pay_d.b   = MAX_WIDTH'(b);
            s1_pay_d.op  = op_e'(op);
            s1_pay_d.acc = acc;
        end else if (s1_xfer) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        y_d         = y_q;
        zero_d      = zero_q;
        ones_d      = ones_q;
        parity_d    = parity_q;
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                y_d      = core_y;
                zero_d   = core_zero;
                ones_d   = core_ones;
                parity_d = core_parity;
            end
        end
    end

    // acc_clr has priority over the load from a transferring beat.
    always_comb begin
        acc_d = acc_q;
        if (acc_clr) begin
            acc_d = ACC_INIT;
        end else if (s1_xfer) begin
            acc_d = core_y;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_pay_q    <= '0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            zero_q      <= 1'b0;
            ones_q      <= 1'b0;
            parity_q    <= 1'b0;
            acc_q       <= ACC_INIT;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_pay_q    <= s1_pay_d;
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            zero_q      <= zero_d;
            ones_q      <= ones_d;
            parity_q    <= parity_d;
            acc_q       <= acc_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign y          = y_q;
    assign out_zero   = zero_q;
    assign out_ones   = ones_q;
    assign out_parity = parity_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// ---------------------------------------------------------------------------
// tb_logic_unit_pipe
// Directed bench for logic_unit_pipe at WIDTH = 8, 1 and 64.
// ---------------------------------------------------------------------------
module tb_logic_unit_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // WIDTH=8 instance
    logic       in_valid, in_ready, acc, acc_clr;
    logic       out_valid, out_ready, out_zero, out_ones, out_parity;
    logic [7:0] a, b, y;
    logic [2:0] op;

    // WIDTH=1 instance
    logic       w1_in_valid, w1_in_ready, w1_out_valid, w1_out_ready;
    logic [0:0] w1_a, w1_b, w1_y;
    logic [2:0] w1_op;
    logic       w1_zero, w1_ones, w1_parity;

    // WIDTH=64 instance
    logic        w64_in_valid, w64_in_ready, w64_out_valid, w64_out_ready;
    logic [63:0] w64_a, w64_b, w64_y;
    logic [2:0]  w64_op;
    logic        w64_zero, w64_ones, w64_parity;

    logic_unit_pipe #(.WIDTH(8), .ACC_INIT(8'h00)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .acc(acc), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready), .y(y),
        .out_zero(out_zero), .out_ones(out_ones), .out_parity(out_parity)
    );

    logic_unit_pipe #(.WIDTH(1), .ACC_INIT(1'b0)) dut_w1 (
        .clk(clk), .rst(rst), .in_valid(w1_in_valid), .in_ready(w1_in_ready),
        .a(w1_a), .b(w1_b), .op(w1_op), .acc(1'b0), .acc_clr(1'b0),
        .out_valid(w1_out_valid), .out_ready(w1_out_ready), .y(w1_y),
        .out_zero(w1_zero), .out_ones(w1_ones), .out_parity(w1_parity)
    );

    logic_unit_pipe #(.WIDTH(64), .ACC_INIT(64'h0)) dut_w64 (
        .clk(clk), .rst(rst), .in_valid(w64_in_valid), .in_ready(w64_in_ready),
        .a(w64_a), .b(w64_b), .op(w64_op), .acc(1'b0), .acc_clr(1'b0),
        .out_valid(w64_out_valid), .out_ready(w64_out_ready), .y(w64_y),
        .out_zero(w64_zero), .out_ones(w64_ones), .out_parity(w64_parity)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0] y;
        int         cyc;
        bit         lat;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] held_y;
    bit         stalled = 0;

    // Output monitor: every consumed beat must match the next expected one.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_beat", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check("y", y, e.y);
                check("zero", out_zero, e.y == 8'h00);
                check("ones", out_ones, e.y == 8'hFF);
                check("parity", out_parity, ^e.y);
                if (e.lat) check("latency", 64'(cyc - e.cyc), 64'd2);
            end
        end
        if (!rst && out_valid && !out_ready) begin
            if (stalled) check("stall_hold", y, held_y);
            stalled = 1;
            held_y  = y;
        end else begin
            stalled = 0;
        end
    end

    task automatic send(input logic [7:0] ta, input logic [7:0] tb_v, input logic [2:0] t_op,
                        input logic t_acc, input logic [7:0] ey, input bit track, input bit lat);
        int k;
        a = ta; b = tb_v; op = t_op; acc = t_acc; in_valid = 1'b1;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (k == 50) check("accept_timeout", 64'(in_ready), 64'd1);
        else if (track) exp_q.push_back('{ey, cyc, lat});
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 60 && exp_q.size() != 0; k++) @(negedge clk);
        check("drain", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    logic [7:0] t1_exp [8];
    logic [3:0] tt     [8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        t1_exp = '{8'h81, 8'hE7, 8'h7E, 8'h18, 8'h66, 8'h99, 8'h3C, 8'hA5};
        // 1-bit truth tables indexed by {a,b}
        tt = '{4'b1000, 4'b1110, 4'b0111, 4'b0001, 4'b0110, 4'b1001, 4'b0011, 4'b1010};

        rst = 1'b1;
        in_valid = 0; a = 0; b = 0; op = 0; acc = 0; acc_clr = 0; out_ready = 1;
        w1_in_valid = 0; w1_a = 0; w1_b = 0; w1_op = 0; w1_out_ready = 1;
        w64_in_valid = 0; w64_a = 0; w64_b = 0; w64_op = 0; w64_out_ready = 1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_y", y, 0);
        check("rst_zero", out_zero, 0);
        check("rst_ones", out_ones, 0);
        check("rst_parity", out_parity, 0);
        check("rst_w64_valid", w64_out_valid, 0);
        @(posedge clk); #1;

        // all eight ops back-to-back, 2-cycle latency
        for (int i = 0; i < 8; i++)
            send(8'hC3, 8'hA5, 3'(i), 1'b0, t1_exp[i], 1, 1);
        drain();

        // accumulate chain
        acc_clr = 1'b1;
        @(posedge clk); #1;
        acc_clr = 1'b0;
        send(8'hA5, 8'h01, 3'd4, 1'b1, 8'h01, 1, 0);
        send(8'hA5, 8'h02, 3'd4, 1'b1, 8'h03, 1, 0);
        send(8'hA5, 8'h04, 3'd4, 1'b1, 8'h07, 1, 0);
        send(8'hA5, 8'h08, 3'd4, 1'b1, 8'h0F, 1, 0);
        send(8'hA5, 8'h00, 3'd6, 1'b1, 8'hF0, 1, 0);
        send(8'hA5, 8'h0F, 3'd1, 1'b1, 8'hFF, 1, 0);
        drain();

        // back-pressure: out_ready low for six cycles mid-stream
        fork
            begin
                for (int i = 0; i < 5; i++)
                    send(8'h00, 8'(8'h10 * (i + 1)), 3'd7, 1'b0, 8'(8'h10 * (i + 1)), 1, 0);
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                @(negedge clk);
                check("bp_in_ready", in_ready, 0);
                check("bp_out_valid", out_valid, 1);
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // reset with both stages full; neither beat may ever appear
        out_ready = 1'b0;
        send(8'h5A, 8'h00, 3'd1, 1'b0, 8'h00, 0, 0);
        send(8'h00, 8'hBB, 3'd7, 1'b0, 8'h00, 0, 0);
        @(negedge clk);
        check("full_in_ready", in_ready, 0);
        check("full_y", y, 8'h5A);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_y", y, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        // accumulator back at ACC_INIT (it held 5A before reset)
        send(8'hFF, 8'h00, 3'd4, 1'b1, 8'h00, 1, 0);
        drain();

        // acc_clr on the edge an acc beat transfers S1 -> S2
        send(8'h33, 8'h00, 3'd4, 1'b0, 8'h33, 1, 0);
        send(8'h00, 8'h0F, 3'd4, 1'b1, 8'h3C, 1, 0);
        acc_clr = 1'b1;
        send(8'h00, 8'h55, 3'd4, 1'b1, 8'h55, 1, 0);
        acc_clr = 1'b0;
        send(8'h00, 8'hAA, 3'd4, 1'b1, 8'hFF, 1, 0);
        drain();

        // WIDTH=1 truth tables
        for (int o = 0; o < 8; o++) begin
            for (int ab = 0; ab < 4; ab++) begin
                logic [3:0] row;
                logic [1:0] abv;
                row = tt[o];
                abv = 2'(ab);
                w1_a = abv[1]; w1_b = abv[0]; w1_op = 3'(o); w1_in_valid = 1'b1;
                @(posedge clk); #1;
                w1_in_valid = 1'b0;
                @(posedge clk);
                @(negedge clk);
                check("w1_valid", w1_out_valid, 1);
                check("w1_y", w1_y, row[abv]);
                check("w1_ones", w1_ones, row[abv]);
            end
        end

        // WIDTH=64 corners
        w64_a = '1; w64_b = '0; w64_op = 3'd3; w64_in_valid = 1'b1;
        @(posedge clk); #1;
        w64_in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("w64_nor_valid", w64_out_valid, 1);
        check("w64_nor_y", w64_y, 64'h0);
        check("w64_nor_zero", w64_zero, 1);
        check("w64_nor_ones", w64_ones, 0);
        @(posedge clk); #1;
        w64_a = '0; w64_b = 64'h1234; w64_op = 3'd6; w64_in_valid = 1'b1;
        @(posedge clk); #1;
        w64_in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("w64_nota_y", w64_y, 64'hFFFF_FFFF_FFFF_FFFF);
        check("w64_nota_ones", w64_ones, 1);
        check("w64_nota_parity", w64_parity, 0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
